dma_tdd_sync_ctrl: RTL and testbench
====================================

Name: dma_tdd_sync_ctrl

Overview:
- Sequencer for DMA TDD synchronisation.
- Arms on software enable and waits for a trigger, either a masked rising edge on one of NUM_TRIG trigger inputs or a software strobe.
- After a programmable delay, emits a burst of sync pulses with programmable pulse width and period.
- Sits between the trigger sources/register map and the DMA sync inputs. Reports busy/done/overflow status to the register map.

Parameters:
- NUM_TRIG, 4: number of hardware trigger inputs.
- CNT_WIDTH, 32: width of the delay, period, pulse-width and frame counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- enable  in  1  level; 1 arms/runs the sequencer, 0 aborts and idles.
- trig_in  in  NUM_TRIG  hardware triggers; already synchronous to clk.
- trig_mask  in  NUM_TRIG  1 = trigger input participates.
- sw_trig  in  1  single-cycle software trigger.
- cfg_delay  in  CNT_WIDTH  cycles from trigger detection to first pulse.
- cfg_pulse_width  in  CNT_WIDTH  sync_out high cycles; 0 treated as 1.
- cfg_period  in  CNT_WIDTH  pulse start-to-start cycles.
- cfg_burst  in  CNT_WIDTH  pulses per trigger; 0 = continuous until enable=0.
- sync_out  out  1  sync pulse to DMA.
- busy  out  1  high in ARMED, DELAY, PULSE, GAP.
- done  out  1  one-cycle strobe on burst completion.
- overflow  out  1  sticky: trigger arrived while a burst was active.
- frame_cnt  out  CNT_WIDTH  pulses issued since last arm.

Behaviour:
- Reset is synchronous, active-low rstn; clock clk.
- Reset values: all outputs 0, state IDLE, edge registers 0.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE. All outputs are registered.
- Trigger event: (trig_in & trig_mask & ~trig_in_q) != 0, or sw_trig. trig_in_q is the previous-cycle sample and updates in every state.
- IDLE: enable=1 -> ARMED. On this transition, latch all cfg_* inputs, clear frame_cnt and clear overflow. cfg_* changes after that point are ignored until the next arm.
- ARMED: on a trigger event -> DELAY with counter = cfg_delay. If cfg_delay=0 -> PULSE directly.
- Pulse timing:
  - Trigger sampled at edge k with delay D gives sync_out=1 from edge k+1+D.
  - D=0 gives sync_out=1 from edge k+1.
- DELAY: decrement the counter; when it reaches 1 -> PULSE.
- PULSE:
  - sync_out=1 for exactly max(cfg_pulse_width,1) cycles.
  - frame_cnt increments on the first cycle of each pulse.
  - At pulse end: if cfg_burst!=0 and frame_cnt==cfg_burst -> DONE; else -> GAP.
- GAP:
  - Length = cfg_period - pw when cfg_period > pw; otherwise 1 cycle.
  - Resulting start-to-start spacing = max(cfg_period, pw+1).
  - GAP -> PULSE.
- DONE: done=1 on the entry cycle only. Remain in DONE until enable=0, then -> IDLE. Re-arming requires enable to go low then high.
- Abort: enable=0 in ARMED/DELAY/PULSE/GAP -> IDLE next edge; sync_out=0 from that edge; frame_cnt holds its value; done is not asserted.
- Overflow: a trigger event in DELAY/PULSE/GAP sets overflow and is otherwise ignored, with no restart.
- Simultaneous events:
  - Trigger and enable falling in the same cycle: abort wins.
  - Trigger in the same cycle as the IDLE->ARMED transition: ignored.
- frame_cnt wraps modulo 2^CNT_WIDTH in continuous mode. Counters never underflow.

Decomposition:
- Package dma_tdd_sync_pkg: state enum, CNT_WIDTH default, helper constant for pw clamp.
- Sub-module dma_tdd_sync_trig: masked rising-edge detector OR'd with sw_trig; one output, trig_event.
- Top contains the FSM and counters.

Test Plan:
- Delay=0, pw=4, period=10, burst=3; sw_trig one cycle after arm -> three 4-cycle pulses starting 10 cycles apart, frame_cnt=3, done one cycle, busy falls with done.
- trig_mask=0010, rising edge on trig_in[0] then trig_in[1], delay=5 -> [0] ignored; sync_out rises exactly 6 edges after [1] is sampled.
- burst=0, pw=2, period=2 -> continuous pulses of 2 high, 1 low; enable dropped mid-pulse -> sync_out low next edge, done stays 0, frame_cnt held.
- Second trigger during GAP of burst=2 -> overflow=1, burst completes normally with frame_cnt=2; overflow clears on next arm.
- pw=0, period=0, burst=1, delay=3 -> single 1-cycle pulse, then DONE; cfg changes during the run have no effect.
- rstn asserted during PULSE -> all outputs 0 next edge, state IDLE; arm/trigger afterwards works normally.

Source files
------------

// File: rtl/dma_tdd_sync_ctrl_pkg.sv
// Shared types and constants for the DMA TDD sync sequencer.
package dma_tdd_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_TRIG_DEF  = 4;
    localparam int unsigned CNT_WIDTH_DEF = 32;
    // Smallest pulse width; a programmed width of 0 is raised to this.
    localparam int unsigned PW_MIN        = 1;

endpackage

// File: rtl/dma_tdd_sync_ctrl_if.sv
// Trigger/config/status bundle between register map, trigger sources and the sequencer.
interface dma_tdd_sync_ctrl_if
    import dma_tdd_sync_pkg::*;
#(
    parameter int unsigned NUM_TRIG  = NUM_TRIG_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) ();

    logic                 enable;
    logic [NUM_TRIG-1:0]  trig_in;
    logic [NUM_TRIG-1:0]  trig_mask;
    logic                 sw_trig;
    logic [CNT_WIDTH-1:0] cfg_delay;
    logic [CNT_WIDTH-1:0] cfg_pulse_width;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [CNT_WIDTH-1:0] cfg_burst;
    logic                 sync_out;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] frame_cnt;

    modport master (
        output enable, trig_in, trig_mask, sw_trig,
        output cfg_delay, cfg_pulse_width, cfg_period, cfg_burst,
        input  sync_out, busy, done, overflow, frame_cnt
    );

    modport slave (
        input  enable, trig_in, trig_mask, sw_trig,
        input  cfg_delay, cfg_pulse_width, cfg_period, cfg_burst,
        output sync_out, busy, done, overflow, frame_cnt
    );

endinterface

// File: rtl/dma_tdd_sync_ctrl_trig.sv
// Masked rising-edge trigger detector merged with the software strobe; registered event.
module dma_tdd_sync_trig #(
    parameter int unsigned NUM_TRIG = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_TRIG-1:0] trig_in,
    input  logic [NUM_TRIG-1:0] trig_mask,
    input  logic                sw_trig,
    output logic                trig_event
);

    logic [NUM_TRIG-1:0] trig_in_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            trig_in_q  <= '0;
            trig_event <= 1'b0;
        end else begin
            trig_in_q  <= trig_in;
            trig_event <= (|(trig_in & trig_mask & ~trig_in_q)) | sw_trig;
        end
    end

endmodule

// File: rtl/dma_tdd_sync_ctrl.sv
// DMA TDD sync sequencer: arm, wait for trigger, delay, then emit a burst of sync pulses.
module dma_tdd_sync_ctrl
    import dma_tdd_sync_pkg::*;
#(
    parameter int unsigned NUM_TRIG  = NUM_TRIG_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input logic              clk,
    input logic              rstn,
    dma_tdd_sync_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] PW_LOW = CNT_WIDTH'(PW_MIN);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] lat_delay;
    logic [CNT_WIDTH-1:0] lat_pw;
    logic [CNT_WIDTH-1:0] lat_gap;
    logic [CNT_WIDTH-1:0] lat_burst;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0] pw_clamp;
    logic [CNT_WIDTH-1:0] gap_len;
    logic                 sync_out;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic                 trig_event;
    logic                 trig_ok;

    dma_tdd_sync_trig #(.NUM_TRIG(NUM_TRIG)) u_trig (
        .clk        (clk),
        .rstn       (rstn),
        .trig_in    (bus.trig_in),
        .trig_mask  (bus.trig_mask),
        .sw_trig    (bus.sw_trig),
        .trig_event (trig_event)
    );

    always_comb begin
        pw_clamp = (bus.cfg_pulse_width == '0) ? PW_LOW : bus.cfg_pulse_width;
        gap_len  = (bus.cfg_period > pw_clamp) ? (bus.cfg_period - pw_clamp) : ONE;
    end

    // trig_ok masks the registered event that was sampled on the arming edge itself.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_delay <= '0;
            lat_pw    <= '0;
            lat_gap   <= '0;
            lat_burst <= '0;
            frame_cnt <= '0;
            sync_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            trig_ok   <= 1'b0;
        end else begin
            done    <= 1'b0;
            trig_ok <= (state == ST_ARMED);
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state     <= ST_ARMED;
                        busy      <= 1'b1;
                        lat_delay <= bus.cfg_delay;
                        lat_pw    <= pw_clamp;
                        lat_gap   <= gap_len;
                        lat_burst <= bus.cfg_burst;
                        frame_cnt <= '0;
                        overflow  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (trig_ok && trig_event) begin
                        if (lat_delay == '0) begin
                            state     <= ST_PULSE;
                            sync_out  <= 1'b1;
                            frame_cnt <= frame_cnt + ONE;
                            cnt       <= lat_pw;
                        end else begin
                            state <= ST_DELAY;
                            cnt   <= lat_delay;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (trig_event) overflow <= 1'b1;
                        if (cnt == ONE) begin
                            state     <= ST_PULSE;
                            sync_out  <= 1'b1;
                            frame_cnt <= frame_cnt + ONE;
                            cnt       <= lat_pw;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (!bus.enable) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        sync_out <= 1'b0;
                    end else begin
                        if (trig_event) overflow <= 1'b1;
                        if (cnt == ONE) begin
                            sync_out <= 1'b0;
                            if ((lat_burst != '0) && (frame_cnt == lat_burst)) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                                cnt   <= lat_gap;
                            end
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (trig_event) overflow <= 1'b1;
                        if (cnt == ONE) begin
                            state     <= ST_PULSE;
                            sync_out  <= 1'b1;
                            frame_cnt <= frame_cnt + ONE;
                            cnt       <= lat_pw;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.enable) state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    sync_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sync_out  = sync_out;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.overflow  = overflow;
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_dma_tdd_sync_ctrl.sv
// Directed bench for dma_tdd_sync_ctrl with a pulse-timing scoreboard.
module tb_dma_tdd_sync_ctrl;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    dma_tdd_sync_ctrl_if #(.NUM_TRIG(4), .CNT_WIDTH(32)) bus ();

    dma_tdd_sync_ctrl #(.NUM_TRIG(4), .CNT_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int start;
        int width;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rise_cyc = 0;
    int   cur_w = 0;
    int   done_cnt = 0;
    int   k;
    int   done_base;
    bit   prev_sync = 1'b0;
    bit   done_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: advance to just after the edge, then check pulse edges against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (bus.sync_out && !prev_sync) begin
            rise_cyc = cyc;
            chk("pulse_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_start", cyc, e.start);
                cur_w = e.width;
            end
        end
        if (!bus.sync_out && prev_sync) chk("pulse_width", cyc - rise_cyc, cur_w);
        if (bus.done) done_cnt++;
        prev_sync = bus.sync_out;
    endtask

    task automatic push_burst(input int kk, input int d, input int pw, input int per, input int n);
        int pwe;
        int sp;
        exp_t e;
        pwe = (pw == 0) ? 1 : pw;
        sp  = (per > pwe) ? per : pwe + 1;
        for (int i = 0; i < n; i++) begin
            e.start = kk + 1 + d + i * sp;
            e.width = pwe;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
            if (bus.done) done_seen = 1'b1;
        end
        chk("done_seen", done_seen, 1'b1);
    endtask

    task automatic set_cfg(input int d, input int pw, input int per, input int b);
        bus.cfg_delay       = d;
        bus.cfg_pulse_width = pw;
        bus.cfg_period      = per;
        bus.cfg_burst       = b;
    endtask

    task automatic tick_until(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.enable    = 1'b0;
        bus.trig_in   = '0;
        bus.trig_mask = '0;
        bus.sw_trig   = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_sync", bus.sync_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_frame", bus.frame_cnt, 0);
        rstn = 1'b1;
        tick();

        // Burst of 3, sw trigger one cycle after arm
        set_cfg(0, 4, 10, 3);
        bus.enable = 1'b1;
        tick();
        chk("t1_busy_armed", bus.busy, 1);
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 0, 4, 10, 3);
        tick();
        bus.sw_trig = 1'b0;
        wait_done(100);
        chk("t1_done_cyc", cyc, k + 25);
        chk("t1_busy_fall", bus.busy, 0);
        chk("t1_frame", bus.frame_cnt, 3);
        chk("t1_sb_empty", exp_q.size(), 0);
        tick();
        chk("t1_done_1cyc", bus.done, 0);
        bus.enable = 1'b0;
        tick();

        // Masked triggers: only bit 1 participates, delay 5
        set_cfg(5, 3, 8, 1);
        bus.trig_mask = 4'b0010;
        bus.enable = 1'b1;
        tick();
        tick();
        bus.trig_in = 4'b0001;
        repeat (4) tick();
        chk("t2_ignored", bus.frame_cnt, 0);
        bus.trig_in = 4'b0011;
        k = cyc + 1;
        push_burst(k, 5, 3, 8, 1);
        wait_done(100);
        chk("t2_rise", rise_cyc, k + 6);
        chk("t2_done_cyc", cyc, k + 9);
        chk("t2_ovf", bus.overflow, 0);
        bus.trig_in = '0;
        bus.enable  = 1'b0;
        tick();

        // Continuous mode, aborted mid-pulse
        set_cfg(0, 2, 2, 0);
        bus.trig_mask = '0;
        bus.enable = 1'b1;
        tick();
        tick();
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 0, 2, 2, 5);
        tick();
        bus.sw_trig = 1'b0;
        tick_until(k + 10);
        chk("t3_mid_pulse", bus.sync_out, 1);
        done_base = done_cnt;
        bus.enable = 1'b0;
        exp_q.delete();
        cur_w = (k + 11) - rise_cyc;
        tick();
        chk("t3_abort_low", bus.sync_out, 0);
        chk("t3_abort_busy", bus.busy, 0);
        chk("t3_frame", bus.frame_cnt, 4);
        repeat (3) tick();
        chk("t3_frame_held", bus.frame_cnt, 4);
        chk("t3_no_done", done_cnt, done_base);

        // Overflow from a trigger during GAP
        set_cfg(2, 2, 6, 2);
        bus.enable = 1'b1;
        tick();
        tick();
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 2, 2, 6, 2);
        tick();
        bus.sw_trig = 1'b0;
        tick_until(k + 5);
        bus.sw_trig = 1'b1;
        tick();
        bus.sw_trig = 1'b0;
        wait_done(100);
        chk("t4_done_cyc", cyc, k + 11);
        chk("t4_ovf", bus.overflow, 1);
        chk("t4_frame", bus.frame_cnt, 2);
        bus.enable = 1'b0;
        tick();
        chk("t4_ovf_sticky", bus.overflow, 1);
        bus.enable = 1'b1;
        tick();
        chk("t4_ovf_clr", bus.overflow, 0);
        chk("t4_frame_clr", bus.frame_cnt, 0);
        bus.enable = 1'b0;
        tick();

        // pw=0/period=0 single pulse; cfg changed after arm
        set_cfg(3, 0, 0, 1);
        bus.enable = 1'b1;
        tick();
        set_cfg(0, 7, 20, 5);
        tick();
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 3, 0, 0, 1);
        tick();
        bus.sw_trig = 1'b0;
        wait_done(100);
        chk("t5_done_cyc", cyc, k + 5);
        chk("t5_frame", bus.frame_cnt, 1);
        repeat (5) tick();
        chk("t5_busy_done", bus.busy, 0);
        chk("t5_frame_hold", bus.frame_cnt, 1);
        bus.enable = 1'b0;
        tick();

        // Reset during PULSE, then a normal run
        set_cfg(0, 5, 10, 2);
        bus.enable = 1'b1;
        tick();
        tick();
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 0, 5, 10, 2);
        tick();
        bus.sw_trig = 1'b0;
        tick_until(k + 2);
        chk("t6_in_pulse", bus.sync_out, 1);
        rstn = 1'b0;
        exp_q.delete();
        cur_w = (k + 3) - rise_cyc;
        tick();
        chk("t6_rst_sync", bus.sync_out, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_frame", bus.frame_cnt, 0);
        chk("t6_rst_ovf", bus.overflow, 0);
        rstn = 1'b1;
        bus.enable = 1'b0;
        tick();
        set_cfg(1, 2, 4, 2);
        bus.enable = 1'b1;
        tick();
        tick();
        bus.sw_trig = 1'b1;
        k = cyc + 1;
        push_burst(k, 1, 2, 4, 2);
        tick();
        bus.sw_trig = 1'b0;
        wait_done(100);
        chk("t6_done_cyc", cyc, k + 8);
        chk("t6_frame", bus.frame_cnt, 2);
        chk("t6_sb_empty", exp_q.size(), 0);
        bus.enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
